// File: rtl/axil_crossbar_pkg.sv
// Shared definitions for the AXI-lite crossbar: grant FSM state encoding and
// the grant-index width helper.
package axil_crossbar_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_ADDR = ADDR,
        ST_RESP = RESP
    } state_t;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 1) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/axil_crossbar_rr_select.sv
// Combinational winner select: first set request at or above ptr, else the
// lowest set request. A ptr of 0 degenerates to plain fixed priority.
module axil_crossbar_rr_select
    import axil_crossbar_pkg::*;
#(
    parameter int unsigned S_COUNT = 4,
    parameter int unsigned SEL_W   = sel_width(S_COUNT)
) (
    input  logic [S_COUNT-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [S_COUNT-1:0] grant,
    output logic [SEL_W-1:0]   index,
    output logic               valid
);

    logic [S_COUNT-1:0] mask;
    logic [S_COUNT-1:0] req_hi;
    logic [S_COUNT-1:0] pick;

    always_comb begin
        mask   = '0;
        grant  = '0;
        index  = '0;
        for (int i = 0; i < int'(S_COUNT); i++) begin
            mask[i] = (i >= int'(ptr));
        end
        req_hi = req & mask;
        // Nothing at or above ptr means the search wraps to index 0.
        pick   = (req_hi != '0) ? req_hi : req;
        for (int i = int'(S_COUNT) - 1; i >= 0; i--) begin
            if (pick[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                index    = SEL_W'(i);
            end
        end
        valid = |req;
    end

endmodule

// File: rtl/axil_crossbar_grant.sv
// Per-master-port admission arbiter: holds one grant from address accept to
// response completion. Define AXIL_CROSSBAR_GRANT_RR_EN for round-robin,
// otherwise lowest index wins.
module axil_crossbar_grant
    import axil_crossbar_pkg::*;
#(
    parameter int unsigned S_COUNT = 4,
    parameter int unsigned SEL_W   = sel_width(S_COUNT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [S_COUNT-1:0] s_req,
    output logic [S_COUNT-1:0] s_grant,
    output logic               s_grant_valid,
    output logic [SEL_W-1:0]   s_grant_index,
    input  logic               a_done,
    input  logic               r_done,
    output logic               busy
);

    state_t             state;
    logic [SEL_W-1:0]   ptr;
    logic [S_COUNT-1:0] win_grant;
    logic [SEL_W-1:0]   win_index;
    logic               win_valid;
    logic               release_c;

    axil_crossbar_rr_select #(
        .S_COUNT (S_COUNT),
        .SEL_W   (SEL_W)
    ) u_select (
        .req   (s_req),
        .ptr   (ptr),
        .grant (win_grant),
        .index (win_index),
        .valid (win_valid)
    );

    // Transaction ends on a combined handshake in ADDR or on r_done in RESP.
    assign release_c = ((state == ST_ADDR) && a_done && r_done) ||
                       ((state == ST_RESP) && r_done);

`ifdef AXIL_CROSSBAR_GRANT_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (release_c) begin
            ptr <= (s_grant_index == SEL_W'(S_COUNT - 1)) ? '0 : s_grant_index + 1'b1;
        end
    end
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            s_grant       <= '0;
            s_grant_valid <= 1'b0;
            s_grant_index <= '0;
            busy          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        state         <= ST_ADDR;
                        s_grant       <= win_grant;
                        s_grant_index <= win_index;
                        s_grant_valid <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (a_done && !r_done) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: ;
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            // Index is kept on release so it reads as the last grant.
            if (release_c) begin
                state         <= ST_IDLE;
                s_grant       <= '0;
                s_grant_valid <= 1'b0;
                busy          <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axil_crossbar_grant.sv
// Scoreboard bench for axil_crossbar_grant (S_COUNT=4) with a queue-based
// arbitration reference model; follows AXIL_CROSSBAR_GRANT_RR_EN like the DUT.
module tb_axil_crossbar_grant;

    localparam int unsigned S_COUNT = 4;
    localparam int unsigned SEL_W   = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [S_COUNT-1:0] s_req;
    logic [S_COUNT-1:0] s_grant;
    logic               s_grant_valid;
    logic [SEL_W-1:0]   s_grant_index;
    logic               a_done;
    logic               r_done;
    logic               busy;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int ptr_m    = 0;
    logic prev_valid = 1'b0;

    axil_crossbar_grant #(
        .S_COUNT (S_COUNT),
        .SEL_W   (SEL_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_req         (s_req),
        .s_grant       (s_grant),
        .s_grant_valid (s_grant_valid),
        .s_grant_index (s_grant_index),
        .a_done        (a_done),
        .r_done        (r_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: walk requesters starting at the pointer.
    function automatic int model_pick(input logic [S_COUNT-1:0] req);
`ifdef AXIL_CROSSBAR_GRANT_RR_EN
        for (int k = 0; k < int'(S_COUNT); k++) begin
            int idx;
            idx = (ptr_m + k) % int'(S_COUNT);
            if (req[idx]) return idx;
        end
`else
        for (int k = 0; k < int'(S_COUNT); k++) begin
            if (req[k]) return k;
        end
`endif
        return -1;
    endfunction

    // Monitor: each new grant is matched against the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            check("busy_eq_valid", 32'(busy), 32'(s_grant_valid));
            if (!s_grant_valid) check("grant_zero_idle", 32'(s_grant), 32'd0);
            if (s_grant_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", 32'(s_grant), 32'd0);
                end else begin
                    int e;
                    logic [S_COUNT-1:0] oh;
                    e  = exp_q.pop_front();
                    oh = '0;
                    oh[e] = 1'b1;
                    check("grant_index", 32'(s_grant_index), 32'(e));
                    check("grant_onehot", 32'(s_grant), 32'(oh));
                end
            end
            prev_valid <= s_grant_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; entered and left at #1 after a rising edge.
    task automatic do_txn(input logic [S_COUNT-1:0] req, input int gap,
                          input int a_dly, input int r_dly, input bit both);
        int e;
        int waited;
        for (int i = 0; i < gap; i++) begin
            s_req = '0;
            step();
            check("idle_gap", 32'(s_grant_valid), 32'd0);
        end
        s_req = req;
        e = model_pick(req);
        exp_q.push_back(e);
        step();
        check("grant_latency", 32'(s_grant_valid), 32'd1);
        waited = 0;
        while (!s_grant_valid && waited < 20) begin
            step();
            waited++;
        end
        if (!s_grant_valid) check("grant_timeout", 32'd0, 32'd1);
        for (int i = 0; i < a_dly; i++) begin
            s_req  = S_COUNT'($urandom) | req;
            r_done = 1'($urandom);
            step();
            check("addr_hold", 32'(s_grant_valid), 32'd1);
        end
        a_done = 1'b1;
        r_done = both;
        step();
        a_done = 1'b0;
        r_done = 1'b0;
        if (!both) begin
            check("enter_resp", 32'(s_grant_valid), 32'd1);
            for (int i = 0; i < r_dly; i++) begin
                a_done = 1'($urandom);
                step();
                check("resp_hold", 32'(s_grant_valid), 32'd1);
            end
            a_done = 1'b0;
            r_done = 1'b1;
            step();
            r_done = 1'b0;
        end
        check("release_valid", 32'(s_grant_valid), 32'd0);
        check("release_busy", 32'(busy), 32'd0);
        check("hold_index", 32'(s_grant_index), 32'(e));
        ptr_m = (e + 1) % int'(S_COUNT);
    endtask

    initial begin
        rst    = 1'b1;
        s_req  = '0;
        a_done = 1'b0;
        r_done = 1'b0;
        #1;
        check("rst_grant", 32'(s_grant), 32'd0);
        check("rst_valid", 32'(s_grant_valid), 32'd0);
        check("rst_index", 32'(s_grant_index), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Reset mid-RESP drops the grant asynchronously.
        s_req = 4'b0100;
        exp_q.push_back(model_pick(4'b0100));
        step();
        a_done = 1'b1;
        step();
        a_done = 1'b0;
        check("pre_rst_grant", 32'(s_grant), 32'h4);
        #2 rst = 1'b1;
        #1;
        check("async_rst_grant", 32'(s_grant), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        ptr_m = 0;
        step();
        rst = 1'b0;
        s_req = '0;
        step();
        do_txn(4'b0100, 0, 1, 1, 1'b0);

        // Single requester with spaced handshakes.
        do_txn(4'b0010, 1, 2, 2, 1'b0);

        // All requesting: rotation order (or constant 0 without round-robin).
        for (int t = 0; t < 8; t++) do_txn(4'b1111, 0, 0, 0, 1'b0);

        // Wrap from the top index back to 0.
        do_txn(4'b1000, 0, 0, 0, 1'b1);
        do_txn(4'b1001, 0, 0, 0, 1'b1);
        do_txn(4'b1001, 0, 0, 0, 1'b1);

        // Combined completion in the first ADDR cycle.
        do_txn(4'b0110, 2, 0, 0, 1'b1);

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            logic [S_COUNT-1:0] r;
            r = S_COUNT'($urandom_range(1, 15));
            do_txn(r, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        s_req = '0;
        step();
        step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
